// File: rtl/flp_pkg.sv
// Shared definitions for the FP rounding datapath: rounding-mode encodings
// and width helpers used by the rounder and the divider.
package flp_pkg;

    localparam logic [1:0] FLP_RM_RNE = 2'd0;
    localparam logic [1:0] FLP_RM_RTZ = 2'd1;
    localparam logic [1:0] FLP_RM_RUP = 2'd2;
    localparam logic [1:0] FLP_RM_RDN = 2'd3;

    // Significand bits kept after rounding, hidden bit included.
    function automatic int flp_kept_w(input int swidth);
        return swidth + 1;
    endfunction

    // Rounded sum carries one extra bit to catch carry-out.
    function automatic int flp_sum_w(input int swidth);
        return swidth + 2;
    endfunction

endpackage

// File: rtl/flp_round_dec.sv
// Combinational rounding decision: splits the significand into kept/g/r/s and
// decides the increment and inexact flags for the selected rounding mode.
module flp_round_dec
    import flp_pkg::*;
#(
    parameter int SWIDTH  = 23,
    parameter int RSWIDTH = 2
) (
    input  logic                      sign,
    input  logic [1:0]                rmode,
    input  logic [SWIDTH+RSWIDTH:0]   sg,
    output logic [flp_kept_w(SWIDTH)-1:0] kept,
    output logic                      inc,
    output logic                      inexact
);

    logic g, r, s;

    function automatic logic round_up(input logic [1:0] rm, input logic sgn,
                                      input logic gb, input logic rb, input logic sb);
        case (rm)
            FLP_RM_RNE: return rb & (gb | sb);
            FLP_RM_RTZ: return 1'b0;
            FLP_RM_RUP: return ~sgn & (rb | sb);
            default:    return sgn & (rb | sb);
        endcase
    endfunction

    assign kept    = sg[SWIDTH+RSWIDTH:RSWIDTH];
    assign g       = sg[RSWIDTH];
    assign r       = sg[RSWIDTH-1];
    assign s       = |sg[RSWIDTH-2:0];
    assign inc     = round_up(rmode, sign, g, r, s);
    assign inexact = r | s;

endmodule

// File: rtl/flp_round_pipe.sv
// Two-stage significand rounder with exponent carry adjust and overflow
// saturation, sitting between the normaliser and the result packer.
module flp_round_pipe
    import flp_pkg::*;
#(
    parameter int EWIDTH  = 8,
    parameter int SWIDTH  = 23,
    parameter int RSWIDTH = 2
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic                        i_sign,
    input  logic signed [EWIDTH+1:0]    i_exp,
    input  logic [SWIDTH+RSWIDTH:0]     i_sg,
    input  logic [1:0]                  i_rmode,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_sign,
    output logic signed [EWIDTH+1:0]    o_exp,
    output logic [SWIDTH:0]             o_sg,
    output logic                        o_inexact,
    output logic                        o_ovf
);

    localparam int SUM_W = flp_sum_w(SWIDTH);
    localparam int KEPT_W = flp_kept_w(SWIDTH);
    localparam logic signed [EWIDTH+1:0] EXP_INF = {2'b00, {EWIDTH{1'b1}}};
    localparam logic signed [EWIDTH+1:0] EXP_MAX = {2'b00, {(EWIDTH-1){1'b1}}, 1'b0};

    function automatic logic exp_overflow(input logic signed [EWIDTH+1:0] e);
        return ~e[EWIDTH+1] && (e >= EXP_INF);
    endfunction

    // Directions whose overflow goes to infinity rather than max finite.
    function automatic logic sat_to_inf(input logic [1:0] rm, input logic sgn);
        case (rm)
            FLP_RM_RNE: return 1'b1;
            FLP_RM_RUP: return ~sgn;
            FLP_RM_RDN: return sgn;
            default:    return 1'b0;
        endcase
    endfunction

    logic [KEPT_W-1:0]         kept_p0;
    logic                      inc_p0, inexact_p0;
    logic [SUM_W-1:0]          sum_p0;

    logic                      vld_p1, load_p1;
    logic                      sign_p1, inexact_p1;
    logic signed [EWIDTH+1:0]  exp_p1;
    logic [1:0]                rmode_p1;
    logic [SUM_W-1:0]          sum_p1;

    logic                      carry_p1, ovf_nx;
    logic signed [EWIDTH+1:0]  exp_adj_p1, exp_nx;
    logic [SWIDTH:0]           sg_norm_p1, sg_nx;
    logic                      inexact_nx;

    logic                      vld_p2, load_p2;
    logic                      sign_p2, inexact_p2, ovf_p2;
    logic signed [EWIDTH+1:0]  exp_p2;
    logic [SWIDTH:0]           sg_p2;

    // Stage 0: rounding decision and increment
    flp_round_dec #(
        .SWIDTH (SWIDTH),
        .RSWIDTH(RSWIDTH)
    ) u_dec (
        .sign   (i_sign),
        .rmode  (i_rmode),
        .sg     (i_sg),
        .kept   (kept_p0),
        .inc    (inc_p0),
        .inexact(inexact_p0)
    );

    assign sum_p0 = {1'b0, kept_p0} + {{(SUM_W-1){1'b0}}, inc_p0};

    assign load_p2 = ~vld_p2 | i_ready;
    assign load_p1 = ~vld_p1 | load_p2;
    assign o_ready = load_p1;

    // Stage 1: carry-out normalisation and overflow saturation
    assign carry_p1   = sum_p1[SUM_W-1];
    assign sg_norm_p1 = carry_p1 ? sum_p1[SWIDTH+1:1] : sum_p1[SWIDTH:0];
    assign exp_adj_p1 = exp_p1 + $signed({{(EWIDTH+1){1'b0}}, carry_p1});

    always_comb begin
        exp_nx     = exp_adj_p1;
        sg_nx      = sg_norm_p1;
        inexact_nx = inexact_p1;
        ovf_nx     = 1'b0;
        if (exp_overflow(exp_adj_p1)) begin
            ovf_nx     = 1'b1;
            inexact_nx = 1'b1;
            if (sat_to_inf(rmode_p1, sign_p1)) begin
                exp_nx = EXP_INF;
                sg_nx  = {1'b1, {SWIDTH{1'b0}}};
            end else begin
                exp_nx = EXP_MAX;
                sg_nx  = {(SWIDTH+1){1'b1}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            vld_p1     <= 1'b0;
            sign_p1    <= 1'b0;
            exp_p1     <= '0;
            rmode_p1   <= '0;
            inexact_p1 <= 1'b0;
            sum_p1     <= '0;
            vld_p2     <= 1'b0;
            sign_p2    <= 1'b0;
            exp_p2     <= '0;
            sg_p2      <= '0;
            inexact_p2 <= 1'b0;
            ovf_p2     <= 1'b0;
        end else begin
            if (load_p1) begin
                vld_p1 <= i_valid;
                if (i_valid) begin
                    sign_p1    <= i_sign;
                    exp_p1     <= i_exp;
                    rmode_p1   <= i_rmode;
                    inexact_p1 <= inexact_p0;
                    sum_p1     <= sum_p0;
                end
            end
            if (load_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    sign_p2    <= sign_p1;
                    exp_p2     <= exp_nx;
                    sg_p2      <= sg_nx;
                    inexact_p2 <= inexact_nx;
                    ovf_p2     <= ovf_nx;
                end
            end
        end
    end

    // Stage 2: registered result
    assign o_valid   = vld_p2;
    assign o_sign    = sign_p2;
    assign o_exp     = exp_p2;
    assign o_sg      = sg_p2;
    assign o_inexact = inexact_p2;
    assign o_ovf     = ovf_p2;

endmodule

// File: tb/tb_flp_round_pipe.sv
// Scoreboard bench for flp_round_pipe: random and directed beats checked
// against an arithmetic rounding model, with backpressure and reset cases.
module tb_flp_round_pipe;

    localparam int EW = 8;
    localparam int SW = 23;
    localparam int RS = 2;

    logic            clk = 1'b0;
    logic            nrst;
    logic            i_valid;
    logic            o_ready;
    logic            i_sign;
    logic [EW+1:0]   i_exp;
    logic [SW+RS:0]  i_sg;
    logic [1:0]      i_rmode;
    logic            o_valid;
    logic            i_ready;
    logic            o_sign;
    logic [EW+1:0]   o_exp;
    logic [SW:0]     o_sg;
    logic            o_inexact;
    logic            o_ovf;

    flp_round_pipe #(.EWIDTH(EW), .SWIDTH(SW), .RSWIDTH(RS)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sign   (i_sign),
        .i_exp    (i_exp),
        .i_sg     (i_sg),
        .i_rmode  (i_rmode),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sign   (o_sign),
        .o_exp    (o_exp),
        .o_sg     (o_sg),
        .o_inexact(o_inexact),
        .o_ovf    (o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [36:0] res;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    int          npass = 0;
    int          ntotal = 0;
    int          cyc = 0;
    int          accepted = 0;
    bit          lat_check = 0;
    bit          held_v = 0;
    logic [36:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        ntotal++;
        if (ok) npass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [EW+1:0] ev(input int x);
        logic [31:0] t;
        t = x;
        return t[EW+1:0];
    endfunction

    // Reference: value-level rounding of kept + remainder/2^RS
    function automatic logic [36:0] model(input logic sign, input logic [EW+1:0] e,
                                          input logic [SW+RS:0] sg, input logic [1:0] rm);
        longint kept, rem, half, val;
        int ex;
        bit up, inexact, ovf;
        logic [31:0] ex_bits;
        logic [63:0] val_bits;
        kept = longint'(sg) >> RS;
        rem  = longint'(sg) % (longint'(1) << RS);
        half = longint'(1) << (RS - 1);
        case (rm)
            2'd0: up = (rem > half) || (rem == half && kept % 2 == 1);
            2'd1: up = 1'b0;
            2'd2: up = (rem != 0) && !sign;
            default: up = (rem != 0) && sign;
        endcase
        val = kept + longint'(up);
        ex  = int'($signed(e));
        if (val == (longint'(1) << (SW + 1))) begin
            val = val >> 1;
            ex  = ex + 1;
        end
        inexact = (rem != 0);
        ovf     = (ex >= (1 << EW) - 1);
        if (ovf) begin
            inexact = 1'b1;
            if (rm == 2'd0 || (rm == 2'd2 && !sign) || (rm == 2'd3 && sign)) begin
                ex  = (1 << EW) - 1;
                val = longint'(1) << SW;
            end else begin
                ex  = (1 << EW) - 2;
                val = (longint'(1) << (SW + 1)) - 1;
            end
        end
        ex_bits  = ex;
        val_bits = val;
        return {sign, ex_bits[EW+1:0], val_bits[SW:0], inexact, ovf};
    endfunction

    task automatic send_beat(input logic s, input logic [EW+1:0] e, input logic [SW+RS:0] g, input logic [1:0] rm);
        int guard;
        bit done;
        exp_t x;
        i_valid = 1'b1;
        i_sign  = s;
        i_exp   = e;
        i_sg    = g;
        i_rmode = rm;
        guard   = 0;
        done    = 0;
        while (!done) begin
            @(negedge clk);
            if (o_ready && nrst) begin
                x.res = model(s, e, g, rm);
                x.cyc = cyc;
                sb.push_back(x);
                accepted++;
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                guard++;
                if (guard > 2000) begin
                    chk(1'b0, "accept_timeout", 64'(guard), 64'd2000);
                    done = 1;
                end
            end
        end
    endtask

    task automatic send_random();
        logic [31:0] r;
        logic [SW+RS:0] g;
        int ex;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: g = {{(SW+1){1'b1}}, r[RS-1:0]};
            1: g = '0;
            default: g = {1'b1, r[SW+RS-1:0]};
        endcase
        case ($urandom_range(0, 3))
            0: ex = 240 + int'($urandom_range(0, 15));
            1: ex = -int'($urandom_range(1, 40));
            default: ex = int'($urandom_range(1, 253));
        endcase
        send_beat(r[31], ev(ex), g, r[29:28]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [36:0] cur;
        exp_t x;
        cur = {o_sign, o_exp, o_sg, o_inexact, o_ovf};
        if (!nrst) begin
            held_v = 0;
        end else begin
            if (held_v) chk(o_valid && cur == held, "stall_hold", {26'd0, o_valid, cur}, {26'd0, 1'b1, held});
            held_v = 0;
            if (o_valid) begin
                if (i_ready) begin
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_beat", 64'(cur), 64'd0);
                    end else begin
                        x = sb.pop_front();
                        chk(cur == x.res, "beat", 64'(cur), 64'(x.res));
                        if (lat_check) chk(32'(cyc) - x.cyc == 32'd2, "latency", 64'(32'(cyc) - x.cyc), 64'd2);
                    end
                end else begin
                    held   = cur;
                    held_v = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int vcnt;
        bit bp_done;
        bit stim_done;
        nrst    = 1'b0;
        i_valid = 1'b0;
        i_sign  = 1'b0;
        i_exp   = '0;
        i_sg    = '0;
        i_rmode = 2'd0;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(o_valid == 1'b0, "rst_o_valid", 64'(o_valid), 64'd0);
        chk(o_ovf == 1'b0, "rst_o_ovf", 64'(o_ovf), 64'd0);
        chk(o_inexact == 1'b0, "rst_o_inexact", 64'(o_inexact), 64'd0);
        chk({o_exp, o_sg} == '0, "rst_data", 64'({o_exp, o_sg}), 64'd0);
        chk(o_ready == 1'b1, "rst_o_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        lat_check = 1;
        send_beat(1'b0, ev(127), {24'h800001, 2'b10}, 2'd0);
        send_beat(1'b0, ev(127), {24'h800000, 2'b10}, 2'd0);
        send_beat(1'b0, ev(10),  {24'hFFFFFF, 2'b11}, 2'd0);
        send_beat(1'b0, ev(127), {24'h800000, 2'b01}, 2'd2);
        send_beat(1'b1, ev(127), {24'h800000, 2'b01}, 2'd2);
        send_beat(1'b1, ev(127), {24'h800000, 2'b01}, 2'd3);
        send_beat(1'b0, ev(127), {24'h800000, 2'b01}, 2'd1);
        send_beat(1'b0, ev(127), {24'h800000, 2'b00}, 2'd2);
        send_beat(1'b0, ev(254), {24'hFFFFFF, 2'b11}, 2'd0);
        send_beat(1'b0, ev(255), {24'hFFFFFF, 2'b11}, 2'd1);
        send_beat(1'b1, ev(255), {24'h800000, 2'b00}, 2'd2);
        send_beat(1'b0, ev(0),   26'h0, 2'd0);
        send_beat(1'b1, ev(-3),  {24'hFFFFFF, 2'b11}, 2'd3);
        i_valid = 1'b0;
        wait_drain();
        lat_check = 0;

        i_ready = 1'b0;
        base    = accepted;
        bp_done = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) send_random();
                i_valid = 1'b0;
                bp_done = 1;
            end
        join_none
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk(accepted - base == 2, "bp_buffered", 64'(accepted - base), 64'd2);
        chk(o_ready == 1'b0, "bp_o_ready", 64'(o_ready), 64'd0);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        n = 0;
        while (!bp_done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(bp_done, "bp_complete", 64'(bp_done), 64'd1);
        wait_drain();

        stim_done = 0;
        fork
            begin
                for (int k = 0; k < 300; k++) send_random();
                i_valid   = 1'b0;
                stim_done = 1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_ready = 1'b1;
        wait_drain();

        i_ready = 1'b0;
        send_random();
        send_random();
        i_valid = 1'b0;
        nrst    = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk(o_valid == 1'b0, "mid_rst_o_valid", 64'(o_valid), 64'd0);
        chk(o_ready == 1'b1, "mid_rst_o_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_valid) vcnt++;
        end
        chk(vcnt == 0, "mid_rst_stale", 64'(vcnt), 64'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
